// File: rtl/sync_gray_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : sync_gray_ptr
//  Purpose  : Multi-stage synchroniser for an async-FIFO Gray-coded pointer,
//             with registered Gray-to-binary conversion, per-cycle advance
//             delta, update strobe and a sticky multi-bit-change detector.
//  Ports    : sync_clk     - destination-domain clock
//             sync_rst     - asynchronous active-high reset
//             ptr          - Gray pointer from the source domain (registered
//                            at the source)
//             err_clr      - synchronous clear of sticky ptr_err
//             sync_ptr     - synchronised Gray pointer (last stage)
//             sync_ptr_bin - registered binary equivalent of sync_ptr
//             ptr_delta    - binary advance since previous cycle (modulo)
//             ptr_upd      - one-cycle strobe: sync_ptr_bin changed
//             ptr_err      - sticky: successive Gray samples differed in >1 bit
//  Revision : 1.0 - initial release
// ============================================================================
module sync_gray_ptr #(
  parameter int ASIZE  = 4,
  parameter int STAGES = 2,
  parameter int CHK_EN = 1
) (
  input  logic             sync_clk,
  input  logic             sync_rst,
  input  logic [ASIZE:0]   ptr,
  input  logic             err_clr,
  output logic [ASIZE:0]   sync_ptr,
  output logic [ASIZE:0]   sync_ptr_bin,
  output logic [ASIZE:0]   ptr_delta,
  output logic             ptr_upd,
  output logic             ptr_err
);

  localparam int PW = ASIZE + 1;

  generate
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("sync_gray_ptr: STAGES must be in the range 2..4");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Synchroniser chain: ptr goes straight into stage 0 with no logic in front.
  // --------------------------------------------------------------------------
  logic [PW-1:0] stage_q [STAGES];
  logic [PW-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = ptr;
    for (int k = 1; k < STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge sync_clk or posedge sync_rst) begin
    if (sync_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign sync_ptr = stage_q[STAGES-1];

  // --------------------------------------------------------------------------
  // Binary conversion, delta and update strobe.
  // bin[i] is the XOR of all Gray bits at or above i.
  // --------------------------------------------------------------------------
  logic [PW-1:0] bin_nxt;
  logic [PW-1:0] bin_d,   bin_q;
  logic [PW-1:0] delta_d, delta_q;
  logic          upd_d,   upd_q;

  always_comb begin
    bin_nxt = '0;
    for (int i = 0; i < PW; i++) begin
      bin_nxt[i] = ^(sync_ptr >> i);
    end
    bin_d   = bin_nxt;
    // Modulo subtraction makes the wrap (max -> 0) report a forward step.
    delta_d = bin_nxt - bin_q;
    upd_d   = (bin_nxt != bin_q);
  end

  always_ff @(posedge sync_clk or posedge sync_rst) begin
    if (sync_rst) begin
      bin_q   <= '0;
      delta_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      delta_q <= delta_d;
      upd_q   <= upd_d;
    end
  end

  assign sync_ptr_bin = bin_q;
  assign ptr_delta    = delta_q;
  assign ptr_upd      = upd_q;

  // --------------------------------------------------------------------------
  // Multi-bit-change detector.
  // A valid flag travels alongside the sync chain so the jump from the reset
  // value to the first real sample is never compared; only sample-to-sample
  // transitions of real data can raise ptr_err.
  // --------------------------------------------------------------------------
  generate
    if (CHK_EN != 0) begin : g_chk
      logic [STAGES-1:0] vld_d, vld_q;
      logic [PW-1:0]     prev_g_d, prev_g_q;
      logic              prev_vld_d, prev_vld_q;
      logic              err_d, err_q;
      logic [PW-1:0]     diff;
      logic              multi;

      always_comb begin
        vld_d      = {vld_q[STAGES-2:0], 1'b1};
        prev_g_d   = sync_ptr;
        prev_vld_d = vld_q[STAGES-1];
        diff       = sync_ptr ^ prev_g_q;
        // Clearing the lowest set bit leaves a non-zero value only when at
        // least two bits differ.
        multi      = prev_vld_q && ((diff & (diff - PW'(1))) != '0);
        // A fresh error outranks a simultaneous clear.
        err_d      = multi | (err_q & ~err_clr);
      end

      always_ff @(posedge sync_clk or posedge sync_rst) begin
        if (sync_rst) begin
          vld_q      <= '0;
          prev_g_q   <= '0;
          prev_vld_q <= 1'b0;
          err_q      <= 1'b0;
        end else begin
          vld_q      <= vld_d;
          prev_g_q   <= prev_g_d;
          prev_vld_q <= prev_vld_d;
          err_q      <= err_d;
        end
      end

      assign ptr_err = err_q;
    end else begin : g_no_chk
      assign ptr_err = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_gray_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_gray_ptr
//  Purpose  : Directed self-checking bench for sync_gray_ptr. Two instances
//             (STAGES=2 and STAGES=3) share the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_gray_ptr;

  logic       clk;
  logic       rst;
  logic [4:0] ptr;
  logic       err_clr;

  logic [4:0] s2_sync, s2_bin, s2_delta;
  logic       s2_upd, s2_err;
  logic [4:0] s3_sync, s3_bin, s3_delta;
  logic       s3_upd, s3_err;

  int n_tests = 0;
  int n_fail  = 0;

  sync_gray_ptr #(.ASIZE(4), .STAGES(2), .CHK_EN(1)) u_dut2 (
    .sync_clk     (clk),
    .sync_rst     (rst),
    .ptr          (ptr),
    .err_clr      (err_clr),
    .sync_ptr     (s2_sync),
    .sync_ptr_bin (s2_bin),
    .ptr_delta    (s2_delta),
    .ptr_upd      (s2_upd),
    .ptr_err      (s2_err)
  );

  sync_gray_ptr #(.ASIZE(4), .STAGES(3), .CHK_EN(1)) u_dut3 (
    .sync_clk     (clk),
    .sync_rst     (rst),
    .ptr          (ptr),
    .err_clr      (err_clr),
    .sync_ptr     (s3_sync),
    .sync_ptr_bin (s3_bin),
    .ptr_delta    (s3_delta),
    .ptr_upd      (s3_upd),
    .ptr_err      (s3_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // One active edge, then settle 1 time unit so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset with ptr already at value, then let both instances fill.
  task automatic settle(input logic [4:0] value);
    rst = 1'b1;
    ptr = value;
    step();
    rst = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; ptr = 5'b10110; err_clr = 1'b0;
    step(); step();
    n_tests++; if (s2_sync  !== 5'd0) begin n_fail++; $display("FAIL reset_sync: got %b want 00000", s2_sync); end
    n_tests++; if (s2_bin   !== 5'd0) begin n_fail++; $display("FAIL reset_bin: got %0d want 0", s2_bin); end
    n_tests++; if (s2_delta !== 5'd0) begin n_fail++; $display("FAIL reset_delta: got %0d want 0", s2_delta); end
    n_tests++; if (s2_upd   !== 1'b0) begin n_fail++; $display("FAIL reset_upd: got %b want 0", s2_upd); end
    n_tests++; if (s2_err   !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", s2_err); end
    rst = 1'b0;
    step(); step();
    n_tests++; if (s2_sync !== 5'b10110) begin n_fail++; $display("FAIL rel_sync: got %b want 10110", s2_sync); end
    n_tests++; if (s2_bin  !== 5'd0)     begin n_fail++; $display("FAIL rel_bin_early: got %0d want 0", s2_bin); end
    step();
    n_tests++; if (s2_bin   !== 5'd27) begin n_fail++; $display("FAIL rel_bin: got %0d want 27", s2_bin); end
    n_tests++; if (s2_upd   !== 1'b1)  begin n_fail++; $display("FAIL rel_upd: got %b want 1", s2_upd); end
    n_tests++; if (s2_delta !== 5'd27) begin n_fail++; $display("FAIL rel_delta: got %0d want 27", s2_delta); end
    n_tests++; if (s2_err   !== 1'b0)  begin n_fail++; $display("FAIL rel_err: got %b want 0", s2_err); end
    step();
    n_tests++; if (s2_upd   !== 1'b0) begin n_fail++; $display("FAIL steady_upd: got %b want 0", s2_upd); end
    n_tests++; if (s2_delta !== 5'd0) begin n_fail++; $display("FAIL steady_delta: got %0d want 0", s2_delta); end
  endtask

  task automatic test_single_step();
    int n2, n3, at2, at3;
    logic [4:0] d3;
    n2 = 0; n3 = 0; at2 = 0; at3 = 0; d3 = '0;
    settle(gray(5'd0));
    ptr = gray(5'd1);
    for (int e = 1; e <= 8; e++) begin
      step();
      if (s2_upd) begin n2++; at2 = e; end
      if (s3_upd) begin n3++; at3 = e; d3 = s3_delta; end
    end
    n_tests++; if (n3  !== 1)    begin n_fail++; $display("FAIL step3_pulses: got %0d want 1", n3); end
    n_tests++; if (at3 !== 4)    begin n_fail++; $display("FAIL step3_latency: got %0d want 4", at3); end
    n_tests++; if (d3  !== 5'd1) begin n_fail++; $display("FAIL step3_delta: got %0d want 1", d3); end
    n_tests++; if (s3_err !== 1'b0) begin n_fail++; $display("FAIL step3_err: got %b want 0", s3_err); end
    n_tests++; if (n2  !== 1)    begin n_fail++; $display("FAIL step2_pulses: got %0d want 1", n2); end
    n_tests++; if (at2 !== 3)    begin n_fail++; $display("FAIL step2_latency: got %0d want 3", at2); end
  endtask

  task automatic test_wrap();
    logic [4:0] seq [3];
    int nupd;
    seq[0] = 5'd30; seq[1] = 5'd31; seq[2] = 5'd0;
    nupd = 0;
    settle(gray(5'd29));
    for (int e = 0; e < 8; e++) begin
      if (e < 3) ptr = gray(seq[e]);
      step();
      if (s2_upd) begin
        nupd++;
        n_tests++;
        if (s2_delta !== 5'd1) begin n_fail++; $display("FAIL wrap_delta: got %0d want 1 (update %0d)", s2_delta, nupd); end
      end
    end
    n_tests++; if (nupd   !== 3)    begin n_fail++; $display("FAIL wrap_updates: got %0d want 3", nupd); end
    n_tests++; if (s2_bin !== 5'd0) begin n_fail++; $display("FAIL wrap_bin: got %0d want 0", s2_bin); end
    n_tests++; if (s2_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b want 0", s2_err); end
    n_tests++; if (s3_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err3: got %b want 0", s3_err); end
  endtask

  task automatic test_burst();
    settle(gray(5'd3));
    ptr = 5'b00111;
    step(); step(); step();
    n_tests++; if (s2_delta !== 5'd2) begin n_fail++; $display("FAIL burst_delta: got %0d want 2", s2_delta); end
    n_tests++; if (s2_upd   !== 1'b1) begin n_fail++; $display("FAIL burst_upd: got %b want 1", s2_upd); end
    n_tests++; if (s2_bin   !== 5'd5) begin n_fail++; $display("FAIL burst_bin: got %0d want 5", s2_bin); end
    n_tests++; if (s2_err   !== 1'b1) begin n_fail++; $display("FAIL burst_err: got %b want 1", s2_err); end
    step();
    n_tests++; if (s2_err !== 1'b1) begin n_fail++; $display("FAIL burst_sticky: got %b want 1", s2_err); end
    n_tests++; if (s2_upd !== 1'b0) begin n_fail++; $display("FAIL burst_upd_off: got %b want 0", s2_upd); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_tests++; if (s2_err !== 1'b0) begin n_fail++; $display("FAIL burst_clear: got %b want 0", s2_err); end
  endtask

  task automatic test_clear_collision();
    // Continues from Gray(5) with ptr_err cleared.
    ptr = gray(5'd7);
    step();
    ptr = gray(5'd9);
    step(); step();
    n_tests++; if (s2_err   !== 1'b1) begin n_fail++; $display("FAIL coll_first_err: got %b want 1", s2_err); end
    n_tests++; if (s2_delta !== 5'd2) begin n_fail++; $display("FAIL coll_delta_a: got %0d want 2", s2_delta); end
    err_clr = 1'b1;
    step();
    n_tests++; if (s2_err   !== 1'b1) begin n_fail++; $display("FAIL coll_err_wins: got %b want 1", s2_err); end
    n_tests++; if (s2_delta !== 5'd2) begin n_fail++; $display("FAIL coll_delta_b: got %0d want 2", s2_delta); end
    step();
    err_clr = 1'b0;
    n_tests++; if (s2_err !== 1'b0) begin n_fail++; $display("FAIL coll_clear: got %b want 0", s2_err); end
  endtask

  task automatic test_async_reset();
    ptr = gray(5'd12);
    repeat (6) step();
    // Gray(9) -> Gray(12) flips three bits, so the flag is up before reset.
    n_tests++; if (s2_err !== 1'b1)  begin n_fail++; $display("FAIL ar_pre_err: got %b want 1", s2_err); end
    n_tests++; if (s2_bin !== 5'd12) begin n_fail++; $display("FAIL ar_pre_bin: got %0d want 12", s2_bin); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (s2_sync  !== 5'd0) begin n_fail++; $display("FAIL ar_sync: got %b want 00000", s2_sync); end
    n_tests++; if (s2_bin   !== 5'd0) begin n_fail++; $display("FAIL ar_bin: got %0d want 0", s2_bin); end
    n_tests++; if (s2_delta !== 5'd0) begin n_fail++; $display("FAIL ar_delta: got %0d want 0", s2_delta); end
    n_tests++; if (s2_upd   !== 1'b0) begin n_fail++; $display("FAIL ar_upd: got %b want 0", s2_upd); end
    n_tests++; if (s2_err   !== 1'b0) begin n_fail++; $display("FAIL ar_err: got %b want 0", s2_err); end
    n_tests++; if (s3_err   !== 1'b0) begin n_fail++; $display("FAIL ar_err3: got %b want 0", s3_err); end
    @(posedge clk);
    #1 rst = 1'b0;
    step(); step();
    n_tests++; if (s2_sync !== 5'b01010) begin n_fail++; $display("FAIL ar_rel_sync: got %b want 01010", s2_sync); end
    n_tests++; if (s2_bin  !== 5'd0)     begin n_fail++; $display("FAIL ar_rel_bin_early: got %0d want 0", s2_bin); end
    step();
    n_tests++; if (s2_bin   !== 5'd12) begin n_fail++; $display("FAIL ar_rel_bin: got %0d want 12", s2_bin); end
    n_tests++; if (s2_upd   !== 1'b1)  begin n_fail++; $display("FAIL ar_rel_upd: got %b want 1", s2_upd); end
    n_tests++; if (s2_delta !== 5'd12) begin n_fail++; $display("FAIL ar_rel_delta: got %0d want 12", s2_delta); end
    n_tests++; if (s2_err   !== 1'b0)  begin n_fail++; $display("FAIL ar_rel_err: got %b want 0", s2_err); end
    step();
    n_tests++; if (s2_err !== 1'b0)  begin n_fail++; $display("FAIL ar_rel_err_late: got %b want 0", s2_err); end
    n_tests++; if (s3_bin !== 5'd12) begin n_fail++; $display("FAIL ar_rel_bin3: got %0d want 12", s3_bin); end
    step();
    n_tests++; if (s3_err !== 1'b0) begin n_fail++; $display("FAIL ar_rel_err3: got %b want 0", s3_err); end
  endtask

  initial begin
    rst = 1'b1; ptr = '0; err_clr = 1'b0;
    test_reset();
    test_single_step();
    test_wrap();
    test_burst();
    test_clear_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
